// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// The CPU sees a zero-latency memory on read hits and a stall on misses and stores;
// lines of 4 words are refilled over a req/ack memory handshake.
module dcache_ctrl #(
  parameter int LINES = 16
) (
  input  logic        clk,
  input  logic        rst_,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 32 - 4 - IDX_W;

  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

  state_t             state_reg, state_next;
  logic [1:0]         beat_reg, beat_next;
  logic               mem_req_reg, mem_req_next;
  logic               mem_we_reg, mem_we_next;
  logic [31:0]        mem_addr_reg, mem_addr_next;
  logic [31:0]        mem_wdata_reg, mem_wdata_next;
  logic [31:0]        hit_cnt_reg, miss_cnt_reg;

  logic [LINES-1:0]   valid_vec;
  logic [TAG_W-1:0]   tag_mem [LINES];
  logic [31:0]        data_mem [LINES*4];

  // Address decode for the CPU request and for the latched memory transaction.
  logic [IDX_W-1:0]   cpu_idx, mem_idx;
  logic [TAG_W-1:0]   cpu_tag, mem_tag;
  logic [IDX_W+1:0]   cpu_word, mem_word;
  logic               cpu_hit, mem_hit, ack_ok;
  logic               unused_addr_bits;

  assign cpu_idx  = cpu_addr[IDX_W+3:4];
  assign cpu_tag  = cpu_addr[31:IDX_W+4];
  assign cpu_word = cpu_addr[IDX_W+3:2];
  assign mem_idx  = mem_addr_reg[IDX_W+3:4];
  assign mem_tag  = mem_addr_reg[31:IDX_W+4];
  // During a fill mem_addr_reg tracks base + 4*beat, so its word bits select the beat slot.
  assign mem_word = mem_addr_reg[IDX_W+3:2];
  assign cpu_hit  = valid_vec[cpu_idx] && (tag_mem[cpu_idx] == cpu_tag);
  assign mem_hit  = valid_vec[mem_idx] && (tag_mem[mem_idx] == mem_tag);
  // An ack with no outstanding request is meaningless and must not advance anything.
  assign ack_ok   = mem_ack && mem_req_reg;
  assign unused_addr_bits = &{1'b0, cpu_addr[1:0]};

  logic        stall_int;
  logic        hit_inc, miss_inc;
  logic        line_set, line_clr;
  logic        dmem_we;
  logic [31:0] dmem_wdata;

  // Next-state, registered-output next values and one-cycle strobes.
  always_comb begin
    state_next     = state_reg;
    beat_next      = beat_reg;
    mem_req_next   = mem_req_reg;
    mem_we_next    = mem_we_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    stall_int      = 1'b0;
    hit_inc        = 1'b0;
    miss_inc       = 1'b0;
    line_set       = 1'b0;
    line_clr       = 1'b0;
    dmem_we        = 1'b0;
    dmem_wdata     = mem_rdata;
    case (state_reg)
      IDLE: begin
        if (cpu_wr) begin
          stall_int      = 1'b1;
          state_next     = WRITE;
          mem_req_next   = 1'b1;
          mem_we_next    = 1'b1;
          mem_addr_next  = {cpu_addr[31:2], 2'b00};
          mem_wdata_next = cpu_wdata;
        end else if (cpu_rd) begin
          if (cpu_hit) begin
            hit_inc = 1'b1;
          end else begin
            stall_int     = 1'b1;
            miss_inc      = 1'b1;
            // The victim line is overwritten beat by beat, so it stops being valid now.
            line_clr      = 1'b1;
            state_next    = FILL;
            beat_next     = 2'd0;
            mem_req_next  = 1'b1;
            mem_we_next   = 1'b0;
            mem_addr_next = {cpu_addr[31:4], 4'h0};
          end
        end
      end
      FILL: begin
        stall_int = 1'b1;
        if (ack_ok) begin
          dmem_we = 1'b1;
          if (beat_reg == 2'd3) begin
            line_set     = 1'b1;
            state_next   = IDLE;
            beat_next    = 2'd0;
            mem_req_next = 1'b0;
          end else begin
            beat_next     = beat_reg + 2'd1;
            mem_addr_next = mem_addr_reg + 32'd4;
          end
        end
      end
      WRITE: begin
        stall_int = !ack_ok;
        if (ack_ok) begin
          // Write-through: update the cached copy only if the line is present.
          dmem_we      = mem_hit;
          dmem_wdata   = mem_wdata_reg;
          state_next   = IDLE;
          mem_req_next = 1'b0;
          mem_we_next  = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, handshake registers and saturating performance counters.
  always_ff @(posedge clk) begin
    if (rst_) begin
      state_reg     <= IDLE;
      beat_reg      <= 2'd0;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= 32'd0;
      mem_wdata_reg <= 32'd0;
      hit_cnt_reg   <= 32'd0;
      miss_cnt_reg  <= 32'd0;
    end else begin
      state_reg     <= state_next;
      beat_reg      <= beat_next;
      mem_req_reg   <= mem_req_next;
      mem_we_reg    <= mem_we_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      if (hit_inc && hit_cnt_reg != 32'hFFFF_FFFF)
        hit_cnt_reg <= hit_cnt_reg + 32'd1;
      if (miss_inc && miss_cnt_reg != 32'hFFFF_FFFF)
        miss_cnt_reg <= miss_cnt_reg + 32'd1;
    end
  end

  // Per-line valid bits: set when the last fill beat lands, cleared when a refill starts.
  for (genvar gi = 0; gi < LINES; gi++) begin : g_valid
    logic valid_bit_reg;
    // One valid flop per line, cleared by reset.
    always_ff @(posedge clk) begin
      if (rst_)
        valid_bit_reg <= 1'b0;
      else if (line_set && mem_idx == IDX_W'(gi))
        valid_bit_reg <= 1'b1;
      else if (line_clr && cpu_idx == IDX_W'(gi))
        valid_bit_reg <= 1'b0;
    end
    assign valid_vec[gi] = valid_bit_reg;
  end

  // Tag store, written once per completed refill.
  always_ff @(posedge clk) begin
    if (line_set)
      tag_mem[mem_idx] <= mem_tag;
  end

  // Line data store: fill beats and write-through hits share one write port.
  always_ff @(posedge clk) begin
    if (dmem_we)
      data_mem[mem_word] <= dmem_wdata;
  end

  assign stall     = rst_ ? 1'b0 : stall_int;
  assign cpu_rdata = rst_ ? 32'd0 : data_mem[cpu_word];
  assign mem_req   = mem_req_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign hit_cnt   = hit_cnt_reg;
  assign miss_cnt  = miss_cnt_reg;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed vector table, hand-written
// multi-cycle sequences and a randomized run against a cache/memory model.
module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        rst_ = 1'b1;
  logic        cpu_rd = 1'b0, cpu_wr = 1'b0;
  logic [31:0] cpu_addr = 32'd0, cpu_wdata = 32'd0;
  logic [31:0] cpu_rdata;
  logic        stall;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic [31:0] hit_cnt, miss_cnt;

  dcache_ctrl #(.LINES(16)) dut (
    .clk(clk), .rst_(rst_),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- memory emulator ----------------
  logic [31:0] phys_mem [logic [31:0]];
  logic [31:0] ref_mem  [logic [31:0]];
  logic [31:0] fill_q[$];
  int          wait_mode = 0;   // 0: zero-wait, 1: fixed_wait, 2: random 0..5
  int          fixed_wait = 0;
  int          waits_left = -1;
  int          waits_acc = 0;
  int          req_we_cycles = 0;
  logic        hold = 1'b0;
  logic [31:0] prev_addr, prev_wdata;
  logic        prev_we;
  logic [31:0] last_wr_addr, last_wr_data;

  function automatic int pick_wait();
    if (wait_mode == 0) return 0;
    if (wait_mode == 1) return fixed_wait;
    return int'($urandom_range(0, 5));
  endfunction

  always @(negedge clk) begin
    mem_ack = 1'b0;
    if (rst_ || !mem_req) begin
      waits_left = -1;
      hold = 1'b0;
      // Spurious acks with no request outstanding must be ignored.
      if (!rst_ && wait_mode == 2) mem_ack = 1'($urandom_range(0, 1));
    end else begin
      if (hold) begin
        check("hold_addr", mem_addr, prev_addr);
        check("hold_we", 32'(mem_we), 32'(prev_we));
        check("hold_wdata", mem_wdata, prev_wdata);
      end
      if (mem_we) req_we_cycles++;
      if (waits_left < 0) waits_left = pick_wait();
      if (waits_left == 0) begin
        mem_ack = 1'b1;
        if (mem_we) begin
          phys_mem[mem_addr] = mem_wdata;
          last_wr_addr = mem_addr;
          last_wr_data = mem_wdata;
          mem_rdata = 32'd0;
        end else begin
          mem_rdata = phys_mem.exists(mem_addr) ? phys_mem[mem_addr] : mem_addr;
          fill_q.push_back(mem_addr);
        end
        waits_left = -1;
        hold = 1'b0;
      end else begin
        waits_left--;
        waits_acc++;
        hold = 1'b1;
        prev_addr = mem_addr;
        prev_we = mem_we;
        prev_wdata = mem_wdata;
      end
    end
  end

  // ---------------- CPU-side driver ----------------
  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, output int stalls, output logic [31:0] rdata);
    logic done;
    fill_q.delete();
    waits_acc = 0;
    req_we_cycles = 0;
    last_wr_addr = 32'hFFFF_FFFF;
    last_wr_data = 32'hFFFF_FFFF;
    cpu_rd = rd; cpu_wr = wr; cpu_addr = addr; cpu_wdata = wdata;
    stalls = 0; rdata = 32'd0; done = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk); #1;
      if (!stall) begin
        rdata = cpu_rdata;
        done = 1'b1;
        @(posedge clk); #1;
        break;
      end
      stalls++;
      @(posedge clk); #1;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL access_timeout: addr %h still stalled after 200 cycles, required release", addr);
    end
    cpu_rd = 1'b0; cpu_wr = 1'b0;
    $display("op rd=%0b wr=%0b addr=%h wdata=%h stall=%0d rdata=%h hits=%0d misses=%0d",
             rd, wr, addr, wdata, stalls, rdata, hit_cnt, miss_cnt);
  endtask

  task automatic check_fill(input logic [31:0] addr);
    check("fill_beats", 32'(fill_q.size()), 32'd4);
    for (int k = 0; k < 4 && k < fill_q.size(); k++)
      check($sformatf("fill_addr%0d", k), fill_q[k], {addr[31:4], 4'h0} + 32'(4 * k));
  endtask

  // ---------------- reference cache model ----------------
  logic        ref_valid [16];
  logic [23:0] ref_tag [16];
  logic [31:0] ref_hit, ref_miss;

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : a;
  endfunction

  task automatic ref_reset();
    for (int i = 0; i < 16; i++) ref_valid[i] = 1'b0;
    ref_hit = 32'd0;
    ref_miss = 32'd0;
  endtask

  task automatic run_op(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] a, rdat;
    logic [23:0] tg;
    logic        hit;
    int          idx, st;
    a = {addr[31:2], 2'b00};
    idx = int'(addr[7:4]);
    tg = addr[31:8];
    hit = ref_valid[idx] && (ref_tag[idx] == tg);
    access(rd, wr, addr, wdata, st, rdat);
    if (wr) begin
      check("wr_stall", 32'(st), 32'(1 + waits_acc));
      check("wr_mem_addr", last_wr_addr, a);
      check("wr_mem_data", last_wr_data, wdata);
      ref_mem[a] = wdata;
    end else if (rd) begin
      check("rd_stall", 32'(st), hit ? 32'd0 : 32'(5 + waits_acc));
      check("rd_data", rdat, ref_read(a));
      if (!hit) begin
        check_fill(a);
        ref_valid[idx] = 1'b1;
        ref_tag[idx] = tg;
        ref_miss++;
      end
      ref_hit++;
    end else begin
      check("idle_stall", 32'(st), 32'd0);
    end
    check("hit_cnt", hit_cnt, ref_hit);
    check("miss_cnt", miss_cnt, ref_miss);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          exp_stall;
    logic [31:0] exp_rdata;
    logic [31:0] exp_hit;
    logic [31:0] exp_miss;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  initial begin
    int st;
    logic [31:0] rdat;

    vecs[0]  = '{1'b1, 1'b0, 32'h10,  32'h0,         5, 32'h10,        32'd1, 32'd1};
    vecs[1]  = '{1'b1, 1'b0, 32'h1C,  32'h0,         0, 32'h1C,        32'd2, 32'd1};
    vecs[2]  = '{1'b1, 1'b0, 32'h110, 32'h0,         5, 32'h110,       32'd3, 32'd2};
    vecs[3]  = '{1'b1, 1'b0, 32'h10,  32'h0,         5, 32'h10,        32'd4, 32'd3};
    vecs[4]  = '{1'b0, 1'b1, 32'h14,  32'hDEADBEEF,  1, 32'h0,         32'd4, 32'd3};
    vecs[5]  = '{1'b1, 1'b0, 32'h14,  32'h0,         0, 32'hDEADBEEF,  32'd5, 32'd3};
    vecs[6]  = '{1'b0, 1'b1, 32'h200, 32'h12345678,  1, 32'h0,         32'd5, 32'd3};
    vecs[7]  = '{1'b1, 1'b0, 32'h200, 32'h0,         5, 32'h12345678,  32'd6, 32'd4};
    vecs[8]  = '{1'b1, 1'b0, 32'h204, 32'h0,         0, 32'h204,       32'd7, 32'd4};
    vecs[9]  = '{1'b1, 1'b1, 32'h18,  32'hA5A5A5A5,  1, 32'h0,         32'd7, 32'd4};
    vecs[10] = '{1'b1, 1'b0, 32'h18,  32'h0,         0, 32'hA5A5A5A5,  32'd8, 32'd4};

    // Reset held for two cycles with a read pending.
    cpu_rd = 1'b1; cpu_addr = 32'h10;
    @(posedge clk); #1;
    @(negedge clk); #1;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_rdata", cpu_rdata, 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_hit_cnt", hit_cnt, 32'd0);
    check("rst_miss_cnt", miss_cnt, 32'd0);
    @(posedge clk); #1;
    rst_ = 1'b0; cpu_rd = 1'b0;

    // Directed table with zero-wait memory that returns the address as data.
    wait_mode = 0;
    for (int i = 0; i < NV; i++) begin
      access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, st, rdat);
      check($sformatf("vec%0d_stall", i), 32'(st), 32'(vecs[i].exp_stall));
      if (vecs[i].wr) begin
        check($sformatf("vec%0d_wr_addr", i), last_wr_addr, {vecs[i].addr[31:2], 2'b00});
        check($sformatf("vec%0d_wr_data", i), last_wr_data, vecs[i].wdata);
        ref_mem[{vecs[i].addr[31:2], 2'b00}] = vecs[i].wdata;
      end else begin
        check($sformatf("vec%0d_rdata", i), rdat, vecs[i].exp_rdata);
        if (vecs[i].exp_stall == 5) check_fill(vecs[i].addr);
      end
      check($sformatf("vec%0d_hit_cnt", i), hit_cnt, vecs[i].exp_hit);
      check($sformatf("vec%0d_miss_cnt", i), miss_cnt, vecs[i].exp_miss);
    end

    // Write hit with the ack delayed three cycles.
    wait_mode = 1; fixed_wait = 3;
    access(1'b0, 1'b1, 32'h14, 32'h0BADF00D, st, rdat);
    check("slow_wr_stall", 32'(st), 32'd4);
    check("slow_wr_req_cycles", 32'(req_we_cycles), 32'd4);
    check("slow_wr_addr", last_wr_addr, 32'h14);
    check("slow_wr_data", last_wr_data, 32'h0BADF00D);
    ref_mem[32'h14] = 32'h0BADF00D;
    wait_mode = 0;
    access(1'b1, 1'b0, 32'h14, 32'h0, st, rdat);
    check("slow_wr_readback_stall", 32'(st), 32'd0);
    check("slow_wr_readback", rdat, 32'h0BADF00D);

    // Reset after two acked fill beats.
    fill_q.delete();
    cpu_rd = 1'b1; cpu_addr = 32'h300;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("midfill_beats", 32'(fill_q.size()), 32'd2);
    rst_ = 1'b1; cpu_rd = 1'b0;
    @(negedge clk); #1;
    check("midfill_rst_stall", 32'(stall), 32'd0);
    check("midfill_rst_rdata", cpu_rdata, 32'd0);
    @(posedge clk); #1;
    rst_ = 1'b0;
    @(negedge clk); #1;
    check("midfill_req_after_rst", 32'(mem_req), 32'd0);
    check("midfill_hit_cnt", hit_cnt, 32'd0);
    check("midfill_miss_cnt", miss_cnt, 32'd0);
    @(posedge clk); #1;
    ref_reset();
    run_op(1'b1, 1'b0, 32'h300, 32'h0);
    run_op(1'b1, 1'b0, 32'h10, 32'h0);

    // Randomized traffic with back-pressure and spurious idle acks.
    wait_mode = 2;
    for (int n = 0; n < 250; n++) begin
      int op;
      logic [31:0] a;
      op = int'($urandom_range(0, 9));
      a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 15)) << 4)
        | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      if (op == 0)      run_op(1'b0, 1'b0, a, 32'h0);
      else if (op <= 6) run_op(1'b1, 1'b0, a, 32'h0);
      else if (op <= 8) run_op(1'b0, 1'b1, a, $urandom);
      else              run_op(1'b1, 1'b1, a, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Direct-mapped, write-through, no-write-allocate data cache controller that sits between the cpu5 data-memory port and main memory. The CPU sees a single-cycle memory on hits and a `stall` on misses and writes. The controller refills 4-word lines over a req/ack memory handshake. Hit and miss counters are exported so the CPU test bench can report cache behaviour at `$finish`.

## Interface
- `LINES`, 16, number of cache lines (power of 2, ≥2)
- `clk` input 1: single clock, all state updates on posedge
- `rst_` input 1: synchronous, active-high reset (sampled on posedge `clk`)
- `cpu_rd` input 1: CPU load request
- `cpu_wr` input 1: CPU store request; wins if asserted together with `cpu_rd`
- `cpu_addr` input 32: byte address; bits [1:0] ignored
- `cpu_wdata` input 32: store data
- `cpu_rdata` output 32: load data, valid when `cpu_rd && !stall`
- `stall` output 1: CPU must hold its request and all inputs stable while high
- `mem_req` output 1: memory request, held until `mem_ack`
- `mem_we` output 1: 1 = write, 0 = read
- `mem_addr` output 32: word-aligned memory address
- `mem_wdata` output 32: memory write data
- `mem_ack` input 1: memory accepts/completes the current beat this cycle
- `mem_rdata` input 32: read data, valid with `mem_ack` when `mem_we=0`
- `hit_cnt` output 32: completed read hits, saturating
- `miss_cnt` output 32: read misses, saturating

## Operation
- Address split: offset = [3:2], index = [3+log2(LINES):4], tag = remaining upper bits. Per line: valid bit, tag, 4×32 data.
- FSM states:
  - IDLE: serve requests.
  - FILL: 4-beat line read, beat counter 0..3.
  - WRITE: single write-through beat.
- IDLE, read hit: `cpu_rdata` = data[index][offset] combinationally. `stall`=0. `hit_cnt`++.
- IDLE, read miss: `stall`=1. Latch line base address. `miss_cnt`++. Go to FILL.
- FILL:
  - `mem_req`=1, `mem_we`=0, `mem_addr` = base + 4×beat. `stall`=1.
  - On `mem_ack`, store `mem_rdata` into word[beat] and increment beat.
  - On the 4th ack: write tag, set valid, go to IDLE. The replayed read then hits.
- IDLE, write (hit or miss): `stall`=1. Latch addr/data. Go to WRITE.
- WRITE:
  - `mem_req`=1, `mem_we`=1, `mem_addr`/`mem_wdata` = latched values.
  - `stall` = `!mem_ack`.
  - On ack: if the line is valid with matching tag, update that word. Go to IDLE. A write miss never allocates.
- Neither `cpu_rd` nor `cpu_wr`: idle, no counter change.
- Counters saturate at 0xFFFF_FFFF; they do not wrap.

## Timing
- Reset (`rst_`=1 at posedge):
  - State IDLE; all valid bits 0; beat counter 0.
  - `mem_req`, `mem_we`, `mem_addr`, `mem_wdata` = 0.
  - `hit_cnt`, `miss_cnt` = 0.
  - `stall` and `cpu_rdata` are forced to 0 while `rst_` is high.
- Reset mid-FILL or mid-WRITE aborts the transaction. `mem_req` is 0 in the cycle after the reset edge. Partially filled lines stay invalid.
- `mem_req`, `mem_we`, `mem_addr`, `mem_wdata` are registered. `stall`, `cpu_rdata` are combinational from inputs plus state.
- Read hit latency: 0 cycles.
- Read miss with zero-wait memory (ack in every req cycle):
  - Cycle 0: miss detected. Cycles 1–4: beats 0–3.
  - `stall` high in cycles 0–4; hit with data in cycle 5.
  - Each memory wait cycle adds exactly 1 cycle.
- Write with zero-wait memory: `stall` high in cycle 0, low in cycle 1 (the ack cycle). The CPU advances at the end of cycle 1.
- Handshake: while `mem_req`=1 without `mem_ack`, `mem_addr`/`mem_we`/`mem_wdata` do not change. The next beat's address appears the cycle after the ack. `mem_req` stays high between fill beats.
- `mem_ack` while `mem_req`=0 is ignored.

## Test plan
- Reset: hold `rst_`=1 for 2 cycles with `cpu_rd`=1 → `stall`=0, `mem_req`=0, counters 0. Release; read 0x10 → misses (valid bits clear).
- Cold read miss with zero-wait memory, where memory returns the address as data:
  - Read 0x10 → `mem_addr` 0x10/0x14/0x18/0x1C in cycles 1–4; `stall` high cycles 0–4.
  - Cycle 5: `cpu_rdata`=0x10, `miss_cnt`=1, `hit_cnt`=1.
  - Then read 0x1C → no stall, `cpu_rdata`=0x1C, `hit_cnt`=2.
- Conflict (`LINES`=16): read 0x10, then 0x110 (same index, different tag) → refill from 0x110. Then read 0x10 → misses again; `miss_cnt`=3.
- Write hit and write miss:
  - With 0x10 cached, write 0x14 ← 0xDEADBEEF with ack delayed 3 cycles → `mem_req`/`mem_we` high, addr/data stable for 4 cycles; `stall` low in the ack cycle.
  - Read 0x14 → hit, returns 0xDEADBEEF.
  - Write 0x200 → no allocate; next read 0x200 misses.
- Reset mid-fill: assert `rst_` after 2 acked beats → next cycle `mem_req`=0. Re-read the same address → full 4-beat refill.
- Back-pressure: random 0–5 wait cycles per fill beat → addresses held until ack, beat order 0..3, correct data after fill. Total stall = 5 + total waits.
